// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline stage enables/flushes, data-memory wait FSM, bus timeout and interrupt drain.
// Optional stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stall_ctrl #(
    parameter int WAIT_MAX     = 16,
    parameter int DRAIN_CYCLES = 3,
    parameter int WID_CNT      = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               IMemReady,
    input  logic               DMemReq,
    input  logic               DMemReady,
    input  logic               LoadUseHazard,
    input  logic               BranchTaken,
    input  logic               IrqReq,
    input  logic               IrqEnable,
    output logic               PcEn,
    output logic               IfRfEn,
    output logic               RfAluEn,
    output logic               AluMemEn,
    output logic               MemWbEn,
    output logic               IfRfFlush,
    output logic               RfAluFlush,
    output logic               IrqAck,
    output logic               BusErr,
    output logic [1:0]         State,
    output logic [WID_CNT-1:0] StallCount
);
    typedef enum logic [1:0] {RUN, DMEM_WAIT, IRQ_DRAIN, IRQ_ENTER} state_t;
    state_t state, stateNext;
    logic [7:0] waitCnt;
    logic [2:0] drainCnt;
    logic [4:0] en;
    logic ifFl, rfFl, ack, err;
    logic memStall;
    assign memStall = DMemReq && !DMemReady;
    assign {PcEn, IfRfEn, RfAluEn, AluMemEn, MemWbEn} = en;
    assign IfRfFlush  = ifFl;
    assign RfAluFlush = rfFl;
    assign IrqAck     = ack;
    assign BusErr     = err;
    assign State      = state;
    always_comb begin
        en = '0;
        ifFl = 1'b0;
        rfFl = 1'b0;
        ack = 1'b0;
        err = 1'b0;
        stateNext = state;
        case (state)
            RUN: begin
                if (memStall) stateNext = DMEM_WAIT;
                else if (IrqReq && IrqEnable) begin
                    en = 5'b01111;
                    ifFl = 1'b1;
                    stateNext = IRQ_DRAIN;
                end else if (LoadUseHazard) begin
                    en = 5'b00111;
                    rfFl = 1'b1;
                end else if (!IMemReady) begin
                    en = 5'b01111;
                    ifFl = 1'b1;
                end else begin
                    en = 5'b11111;
                    ifFl = BranchTaken;
                end
            end
            DMEM_WAIT: begin
                // a late DMemReady in the timeout cycle still completes cleanly
                if (DMemReady || waitCnt == 8'(WAIT_MAX)) begin
                    en = 5'b11111;
                    err = !DMemReady;
                    stateNext = RUN;
                end
            end
            IRQ_DRAIN: begin
                if (!memStall) begin
                    en = 5'b01111;
                    ifFl = 1'b1;
                    if (drainCnt == 3'd0) stateNext = IRQ_ENTER;
                end
            end
            IRQ_ENTER: begin
                en = 5'b11111;
                ifFl = 1'b1;
                ack = 1'b1;
                stateNext = RUN;
            end
        endcase
        if (Reset) begin
            en = '0;
            ifFl = 1'b0;
            rfFl = 1'b0;
            ack = 1'b0;
            err = 1'b0;
        end
    end
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= RUN;
            waitCnt <= '0;
            drainCnt <= '0;
        end else begin
            state <= stateNext;
            if (state == RUN && memStall) waitCnt <= 8'd1;
            else if (state == DMEM_WAIT && stateNext == DMEM_WAIT) waitCnt <= waitCnt + 8'd1;
            if (state == RUN && stateNext == IRQ_DRAIN) drainCnt <= 3'(DRAIN_CYCLES - 1);
            else if (state == IRQ_DRAIN && !memStall && drainCnt != 3'd0) drainCnt <= drainCnt - 3'd1;
        end
    end
`ifdef PIPE_STALL_CNT_EN
    logic [WID_CNT-1:0] stallCnt;
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) stallCnt <= '0;
        else if (!PcEn && !(&stallCnt)) stallCnt <= stallCnt + 1'b1;
    end
    assign StallCount = stallCnt;
`else
    assign StallCount = '0;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed vectors; expectations queued by the driver, checked by a negedge monitor.
module tb_pipe_stall_ctrl;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic IMemReady = 1'b1, DMemReq = 1'b0, DMemReady = 1'b0, LoadUseHazard = 1'b0;
    logic BranchTaken = 1'b0, IrqReq = 1'b0, IrqEnable = 1'b0;
    logic PcEn, IfRfEn, RfAluEn, AluMemEn, MemWbEn, IfRfFlush, RfAluFlush, IrqAck, BusErr;
    logic [1:0] State;
    logic [15:0] StallCount;

    pipe_stall_ctrl #(.WAIT_MAX(16), .DRAIN_CYCLES(3), .WID_CNT(16)) dut (
        .Clock(Clock), .Reset(Reset), .IMemReady(IMemReady), .DMemReq(DMemReq),
        .DMemReady(DMemReady), .LoadUseHazard(LoadUseHazard), .BranchTaken(BranchTaken),
        .IrqReq(IrqReq), .IrqEnable(IrqEnable), .PcEn(PcEn), .IfRfEn(IfRfEn),
        .RfAluEn(RfAluEn), .AluMemEn(AluMemEn), .MemWbEn(MemWbEn), .IfRfFlush(IfRfFlush),
        .RfAluFlush(RfAluFlush), .IrqAck(IrqAck), .BusErr(BusErr), .State(State),
        .StallCount(StallCount)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [10:0] o;
        logic [15:0] sc;
        string       name;
    } exp_t;
    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    int expStall = 0;

    localparam logic [4:0] ALL = 5'b11111, IFB = 5'b01111, LU = 5'b00111, NONE = 5'b00000;

    // {State, PcEn, IfRfEn, RfAluEn, AluMemEn, MemWbEn, IfRfFlush, RfAluFlush, IrqAck, BusErr}
    function automatic logic [10:0] mk(input logic [1:0] st, input logic [4:0] e,
                                       input logic ifl, input logic rfl, input logic ak, input logic er);
        return {st, e, ifl, rfl, ak, er};
    endfunction

    task automatic step(input logic rst, input logic imem, input logic dreq, input logic drdy,
                        input logic lu, input logic br, input logic irq, input logic ie,
                        input logic [10:0] o, input string nm);
        exp_t e;
        @(posedge Clock);
        #1;
        Reset = rst; IMemReady = imem; DMemReq = dreq; DMemReady = drdy;
        LoadUseHazard = lu; BranchTaken = br; IrqReq = irq; IrqEnable = ie;
        e.o = o;
`ifdef PIPE_STALL_CNT_EN
        e.sc = rst ? 16'd0 : 16'(expStall);
        if (rst) expStall = 0;
        else if (!o[8]) expStall++;
`else
        e.sc = 16'd0;
`endif
        e.name = nm;
        q.push_back(e);
    endtask

    always @(negedge Clock) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [10:0] act;
            e = q.pop_front();
            act = {State, PcEn, IfRfEn, RfAluEn, AluMemEn, MemWbEn, IfRfFlush, RfAluFlush, IrqAck, BusErr};
            vectors++;
            if (act !== e.o || StallCount !== e.sc) begin
                miscompares++;
                $display("FAIL %s: got outs=%b cnt=%0d, want outs=%b cnt=%0d", e.name, act, StallCount, e.o, e.sc);
            end
        end
    end

    initial begin
        step(1, 1, 0, 0, 0, 0, 0, 0, mk(0, NONE, 0, 0, 0, 0), "reset");
        step(1, 1, 0, 0, 1, 1, 1, 1, mk(0, NONE, 0, 0, 0, 0), "reset_inputs");
        step(0, 1, 0, 0, 0, 0, 0, 0, mk(0, ALL, 0, 0, 0, 0), "run");
        step(0, 1, 0, 0, 0, 1, 0, 0, mk(0, ALL, 1, 0, 0, 0), "branch");
        step(0, 0, 0, 0, 0, 0, 0, 0, mk(0, IFB, 1, 0, 0, 0), "imiss");
        for (int i = 0; i < 5; i++)
            step(0, 1, 0, 0, 1, 1, 0, 0, mk(0, LU, 0, 1, 0, 0), "loaduse_branch");
        // 4 stalled cycles then ready
        step(0, 1, 1, 0, 0, 0, 0, 0, mk(0, NONE, 0, 0, 0, 0), "dwait_enter");
        for (int i = 0; i < 3; i++)
            step(0, 1, 1, 0, 0, 0, 0, 0, mk(1, NONE, 0, 0, 0, 0), "dwait");
        step(0, 1, 1, 1, 0, 0, 0, 0, mk(1, ALL, 0, 0, 0, 0), "dready");
        step(0, 1, 0, 0, 0, 0, 0, 0, mk(0, ALL, 0, 0, 0, 0), "run_after_wait");
        // timeout in wait cycle 16
        step(0, 1, 1, 0, 0, 0, 0, 0, mk(0, NONE, 0, 0, 0, 0), "to_enter");
        for (int i = 0; i < 15; i++)
            step(0, 1, 1, 0, 0, 0, 0, 0, mk(1, NONE, 0, 0, 0, 0), "to_wait");
        step(0, 1, 1, 0, 0, 0, 0, 0, mk(1, ALL, 0, 0, 0, 1), "timeout");
        step(0, 1, 0, 0, 0, 0, 0, 0, mk(0, ALL, 0, 0, 0, 0), "run_after_to");
        // ready in the timeout cycle wins
        step(0, 1, 1, 0, 0, 0, 0, 0, mk(0, NONE, 0, 0, 0, 0), "tr_enter");
        for (int i = 0; i < 15; i++)
            step(0, 1, 1, 0, 0, 0, 0, 0, mk(1, NONE, 0, 0, 0, 0), "tr_wait");
        step(0, 1, 1, 1, 0, 0, 0, 0, mk(1, ALL, 0, 0, 0, 0), "ready_at_timeout");
        step(0, 1, 0, 0, 0, 0, 0, 0, mk(0, ALL, 0, 0, 0, 0), "run_after_tr");
        step(0, 1, 0, 0, 0, 0, 1, 0, mk(0, ALL, 0, 0, 0, 0), "irq_disabled");
        // interrupt: request dropped and hazards raised mid-drain
        step(0, 1, 0, 0, 0, 0, 1, 1, mk(0, IFB, 1, 0, 0, 0), "irq_run");
        step(0, 1, 0, 0, 1, 1, 0, 1, mk(2, IFB, 1, 0, 0, 0), "drain1");
        step(0, 0, 0, 0, 1, 0, 0, 1, mk(2, IFB, 1, 0, 0, 0), "drain2");
        step(0, 1, 0, 0, 0, 0, 0, 1, mk(2, IFB, 1, 0, 0, 0), "drain3");
        step(0, 1, 0, 0, 0, 0, 0, 1, mk(3, ALL, 1, 0, 1, 0), "irq_enter");
        step(0, 1, 0, 0, 0, 0, 0, 1, mk(0, ALL, 0, 0, 0, 0), "run_after_irq");
        // memory stall during drain holds the drain count
        step(0, 1, 0, 0, 0, 0, 1, 1, mk(0, IFB, 1, 0, 0, 0), "irq2_run");
        step(0, 1, 0, 0, 0, 0, 1, 1, mk(2, IFB, 1, 0, 0, 0), "drain_a");
        step(0, 1, 1, 0, 0, 0, 1, 1, mk(2, NONE, 0, 0, 0, 0), "drain_stall");
        step(0, 1, 1, 0, 0, 0, 1, 1, mk(2, NONE, 0, 0, 0, 0), "drain_stall");
        step(0, 1, 1, 1, 0, 0, 0, 1, mk(2, IFB, 1, 0, 0, 0), "drain_b");
        step(0, 1, 0, 0, 0, 0, 0, 1, mk(2, IFB, 1, 0, 0, 0), "drain_c");
        step(0, 1, 0, 0, 0, 0, 0, 1, mk(3, ALL, 1, 0, 1, 0), "irq2_enter");
        // asynchronous reset mid-wait
        step(0, 1, 1, 0, 0, 0, 0, 0, mk(0, NONE, 0, 0, 0, 0), "ar_enter");
        step(0, 1, 1, 0, 0, 0, 0, 0, mk(1, NONE, 0, 0, 0, 0), "ar_wait");
        step(1, 1, 1, 0, 0, 0, 0, 0, mk(0, NONE, 0, 0, 0, 0), "async_reset");
        step(0, 1, 0, 0, 0, 0, 0, 0, mk(0, ALL, 0, 0, 0, 0), "run_after_reset");
        step(0, 1, 0, 0, 0, 1, 0, 0, mk(0, ALL, 1, 0, 0, 0), "branch_after_reset");
        repeat (3) @(posedge Clock);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_queue: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central sequencer for the pipeline stage registers (enable-gated, no reset of their own) of the 5-stage core: IF, RF, ALU, MEM, WB.
- Takes hazard, memory-ready and interrupt inputs.
- Produces per-stage register enables plus bubble-insert (flush) strobes.
- Contains the data-memory wait FSM, the bus-timeout counter and the interrupt drain sequence.

Parameters:
- WAIT_MAX, 16, maximum DMEM_WAIT cycles before bus timeout (legal range 1..255).
- DRAIN_CYCLES, 3, cycles spent draining the pipeline before interrupt entry (legal range 1..7).
- WID_CNT, 16, width of the optional stall counter.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- IMemReady  in  1  instruction fetch data valid this cycle.
- DMemReq  in  1  MEM stage holds a load/store this cycle.
- DMemReady  in  1  data memory completes the access this cycle.
- LoadUseHazard  in  1  RF-stage operand depends on the load in ALU.
- BranchTaken  in  1  branch/jump resolved taken in RF.
- IrqReq  in  1  level interrupt request.
- IrqEnable  in  1  interrupts permitted (user mode).
- PcEn  out  1  PC register enable.
- IfRfEn, RfAluEn, AluMemEn, MemWbEn  out  1 each  stage register enables.
- IfRfFlush, RfAluFlush  out  1 each  load a NOP into that stage register; only meaningful with the matching En=1.
- IrqAck  out  1  one-cycle pulse; PC loads the interrupt vector.
- BusErr  out  1  one-cycle pulse on data-memory timeout.
- State  out  2  RUN=0, DMEM_WAIT=1, IRQ_DRAIN=2, IRQ_ENTER=3.
- StallCount  out  WID_CNT  optional, see below.

Behaviour:
- Outputs are combinational from state and inputs; state and counters are registered.
- While Reset=1:
  - State=RUN, counters=0.
  - All En/Flush/IrqAck/BusErr=0.
- RUN, priority highest first:
  1. DMemReq && !DMemReady: all En=0; next state DMEM_WAIT; WaitCnt<=1.
  2. IrqReq && IrqEnable: PcEn=0, IfRfEn=1 with IfRfFlush=1, other En=1; next state IRQ_DRAIN; DrainCnt<=DRAIN_CYCLES-1.
  3. LoadUseHazard: PcEn=0, IfRfEn=0; RfAluEn=1 with RfAluFlush=1; AluMemEn=MemWbEn=1.
  4. !IMemReady: PcEn=0; IfRfEn=1 with IfRfFlush=1; others En=1.
  5. BranchTaken: all En=1, IfRfFlush=1.
  6. Otherwise: all En=1, no flush.
- DMEM_WAIT:
  - All En=0 while !DMemReady.
  - DMemReady: all En=1 (no flush) that cycle; next state RUN.
  - Timeout: !DMemReady && WaitCnt==WAIT_MAX gives BusErr=1 and all En=1 that cycle (the load result is undefined); next state RUN.
  - Otherwise WaitCnt increments.
  - DMemReady arriving in the timeout cycle wins; no BusErr.
- IRQ_DRAIN:
  - PcEn=0; IfRfEn=1 with IfRfFlush=1; others En=1; hazards are ignored because bubbles are draining.
  - Advance: DrainCnt==0 moves to IRQ_ENTER; otherwise DrainCnt decrements.
  - DMemReq && !DMemReady takes priority: all En=0 and DrainCnt holds; stay in IRQ_DRAIN until DMemReady, with no timeout tracking here.
- IRQ_ENTER:
  - One cycle: IrqAck=1, PcEn=1, IfRfEn=1 with IfRfFlush=1, others En=1.
  - Next state RUN unconditionally; IrqReq must be deasserted by the handler.
- Deassertion of IrqReq during IRQ_DRAIN does not abort the drain.
- Reset asserted mid-wait or mid-drain immediately returns State to RUN and forces all outputs low.

Optional Feature:
- Macro PIPE_STALL_CNT_EN.
- When defined:
  - StallCount increments on every cycle after reset in which PcEn=0.
  - It saturates at all-ones and is cleared by Reset.
- When undefined:
  - StallCount is driven to 0.
  - The counter flop is absent.

Test Plan:
- Reset asserted mid-cycle → State=0 and PcEn=0 immediately (asynchronous); after release with IMemReady=1 and no hazards, all En=1.
- DMemReq=1 with DMemReady low for 4 cycles, then high → all En=0 for 4 cycles, all En=1 in the 5th; State 0→1→0; BusErr=0.
- WAIT_MAX=16 with DMemReady never high → BusErr=1 exactly in DMEM_WAIT cycle 16, all En=1 that cycle, then State=0.
- IrqReq=1, IrqEnable=1, DRAIN_CYCLES=3 → 1 RUN cycle plus 3 IRQ_DRAIN cycles with PcEn=0 and IfRfFlush=1, then IRQ_ENTER with IrqAck=1 for exactly 1 cycle.
- LoadUseHazard=1 and BranchTaken=1 in the same cycle → PcEn=0, IfRfEn=0, RfAluFlush=1, IfRfFlush=0.
- PIPE_STALL_CNT_EN defined, 5 load-use cycles plus 4 wait cycles → StallCount=9.
